lei_shadow_xbar: RTL
====================

// Module: lei_shadow_xbar
// PURPOSE
//  Parametrised LE-input interconnect crossbar with double-buffered configuration.
//  Routes NUM_SRC LE outputs onto NUM_GROUPS x LE_INPUTS LE inputs, one SEL_W select per input.
//  Config shifts serially into a shadow chain; daisy-chained bitstream; even-parity checked.
//  Committed atomically to an active register, so routing stays live (hitless) while a new
//  bitstream is shifting.
// PARAMETERS
//  LE_INPUTS   4  inputs per LE input group
//  NUM_GROUPS  4  LE input groups (e.g. 0A,0B,1A,1B)
//  NUM_SRC     4  selectable LE output sources
//  REG_OUT     0  1 = register le_in (+1 cycle latency); 0 = combinational from active reg
//  SEL_W       $clog2(NUM_SRC)+1 (derived, localparam)
//  CFG_BITS    NUM_GROUPS*LE_INPUTS*SEL_W+1 (derived; +1 = parity bit; 49 at defaults)
// PORTS
//  clk             in   1                    system clock, all state on rising edge
//  rst             in   1                    asynchronous reset, active-high
//  en              in   1                    clock enable for shift, commit and clear
//  config_en       in   1                    shift strobe (effective only when en=1)
//  config_data_in  in   1                    serial config bit in
//  config_data_out out  1                    shadow[CFG_BITS-1], feeds next block in chain
//  cfg_commit      in   1                    request copy shadow -> active
//  cfg_clear       in   1                    drop active config, return to EMPTY
//  cfg_loaded      out  1                    1 when state==VALID
//  cfg_err         out  1                    sticky: last commit rejected
//  le_out          in   NUM_SRC              LE output sources
//  le_in           out  NUM_GROUPS*LE_INPUTS flat LE inputs; entry k = j*NUM_GROUPS+i
// BEHAVIOUR
//  Reset (rst=1, async): shadow=0, active=0, state=EMPTY, cfg_err=0, cfg_loaded=0,
//   le_in=0, config_data_out=0.
//  Shift: on clk when en&&config_en: shadow <= {shadow[CFG_BITS-2:0], config_data_in}.
//   Active register and le_in are unaffected by shifting.
//  Field map: shadow[0] = parity bit. Select for entry k = shadow[1+k*SEL_W +: SEL_W].
//  Parity: commit legal only if XOR of all CFG_BITS shadow bits == 0 (even parity).
//  Commit: sampled when en&&cfg_commit&&!config_en.
//   Good parity: active <= shadow, state <= VALID, cfg_err <= 0.
//   Bad parity: active and state unchanged, cfg_err <= 1.
//   cfg_commit with config_en=1: shift performed, commit ignored, cfg_err <= 1.
//  Clear: en&&cfg_clear -> active <= 0, state <= EMPTY, cfg_err <= 0.
//   Clear wins over a simultaneous commit. Shadow is not cleared.
//  FSM: EMPTY --good commit--> VALID; VALID --good commit--> VALID (new config);
//   any --clear--> EMPTY.
//  Routing (per entry, combinational from active and le_out):
//   sel < NUM_SRC   -> le_out[sel]
//   sel == all-ones -> 1'b1 (tie-high)
//   else            -> 1'b0
//   State EMPTY forces all le_in to 0.
//  Latency: active updates on the commit edge. REG_OUT=0: le_in valid the same cycle.
//   REG_OUT=1: le_in valid one edge later, and follows le_out with 1-cycle delay.
//  en=0: no shift, commit or clear. le_in still follows le_out through active.
//  rst mid-shift or mid-commit: everything returns to reset values immediately.
// TESTING (defaults; CFG_BITS=49)
//  1 Reset, le_out=4'hF, no config -> le_in=16'h0000, cfg_loaded=0, cfg_err=0.
//  2 Shift 49 bits, all sel=3'b001, parity=0; commit -> next edge cfg_loaded=1;
//    le_out=4'b0010 -> le_in=16'hFFFF; le_out=4'b0000 -> 16'h0000.
//  3 Flip one select bit so parity is odd; commit -> cfg_err=1, le_in keeps
//    test-2 routing; then good stream + commit -> cfg_err=0.
//  4 In VALID, shift 49 bits of all sel=3'b111 with le_out=0 -> le_in stays 0
//    through the whole shift; commit -> le_in=16'hFFFF.
//  5 Chain two instances; push 98 bits -> config_data_out of the first equals
//    the bit input 49 en-cycles earlier; both commit cleanly; en=0 cycles shift nothing.
//  6 cfg_clear+cfg_commit same cycle -> EMPTY, le_in=0. Assert rst mid-shift ->
//    all outputs 0 asynchronously.

Source files
------------

// File: rtl/lei_shadow_xbar.sv
// lei_shadow_xbar: LE-input crossbar with a serially loaded shadow config and atomic commit
//   clk, rst                 clock, asynchronous active-high reset
//   en                       gates shift, commit and clear
//   config_en/config_data_in serial shift strobe and data into the shadow chain
//   config_data_out          shadow MSB, daisy-chains to the next block
//   cfg_commit/cfg_clear     copy shadow -> active (even parity required) / drop config
//   cfg_loaded/cfg_err       active config valid / last commit rejected (sticky)
//   le_out/le_in             LE output sources / routed flat LE inputs
module lei_shadow_xbar #(
   parameter int LE_INPUTS  = 4,
   parameter int NUM_GROUPS = 4,
   parameter int NUM_SRC    = 4,
   parameter int REG_OUT    = 0
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  logic                             config_en,
   input  logic                             config_data_in,
   output logic                             config_data_out,
   input  logic                             cfg_commit,
   input  logic                             cfg_clear,
   output logic                             cfg_loaded,
   output logic                             cfg_err,
   input  logic [NUM_SRC-1:0]               le_out,
   output logic [NUM_GROUPS*LE_INPUTS-1:0]  le_in
);
   localparam int SEL_W    = $clog2(NUM_SRC) + 1;
   localparam int N        = NUM_GROUPS * LE_INPUTS;
   localparam int CFG_BITS = N * SEL_W + 1;
   typedef enum logic {EMPTY, VALID} state_t;
   state_t               state_q;
   logic [CFG_BITS-1:0]  shadow_q, shadow_d;
   logic [CFG_BITS-2:0]  active_q;
   logic                 err_q, par_ok;
   logic [SEL_W-1:0]     sel;
   logic [N-1:0]         le_in_d;
   assign shadow_d        = {shadow_q[CFG_BITS-2:0], config_data_in};
   assign par_ok          = ~^shadow_q;
   assign config_data_out = shadow_q[CFG_BITS-1];
   assign cfg_loaded      = state_q == VALID;
   assign cfg_err         = err_q;
   // active holds only the select fields; the parity bit is never needed after commit
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         shadow_q <= '0;
         active_q <= '0;
         state_q  <= EMPTY;
         err_q    <= 1'b0;
      end else if (en) begin
         if (config_en) shadow_q <= shadow_d;
         if (cfg_clear) begin
            active_q <= '0;
            state_q  <= EMPTY;
            err_q    <= 1'b0;
         end else if (cfg_commit) begin
            if (!config_en && par_ok) begin
               active_q <= shadow_q[CFG_BITS-1:1];
               state_q  <= VALID;
               err_q    <= 1'b0;
            end else err_q <= 1'b1;
         end
      end
   // all-ones select is always >= NUM_SRC, so the tie-high default is overridden only by a real source
   always_comb begin
      le_in_d = '0;
      sel     = '0;
      for (int k = 0; k < N; k++) begin
         sel        = active_q[k*SEL_W +: SEL_W];
         le_in_d[k] = &sel;
         for (int s = 0; s < NUM_SRC; s++)
            if (sel == SEL_W'(s)) le_in_d[k] = le_out[s];
      end
      if (state_q == EMPTY) le_in_d = '0;
   end
   if (REG_OUT != 0) begin : g_reg
      logic [N-1:0] le_in_q;
      always_ff @(posedge clk or posedge rst)
         if (rst) le_in_q <= '0;
         else le_in_q <= le_in_d;
      assign le_in = le_in_q;
   end else begin : g_comb
      assign le_in = le_in_d;
   end
endmodule
